// File: rtl/neuron_mac_seq.sv
// -----------------------------------------------------------------------------
// neuron_mac_seq
//   Sequential multiply-accumulate neuron stage. On an accepted start it takes
//   a snapshot of N_IN data words and N_IN weights, loads the accumulator with
//   the bias, and then adds one Q16.16 product per clock. The sum gets an
//   optional ReLU and is then saturated to DATA_W bits. The result goes to the
//   next layer's register bank.
//
// Ports
//   clk         rising-edge clock
//   reset       synchronous, active-high; takes priority over every other input
//   start       request a computation (accepted in IDLE and in the DONE cycle)
//   relu_en     1 = clamp negative sums to zero; sampled together with start
//   data_vec    N_IN packed signed Q16.16 words, word i at [i*DATA_W +: DATA_W]
//   weight_vec  N_IN packed signed Q16.16 weights, same packing
//   bias        signed Q16.16 bias
//   busy        high from the accept edge until the result edge
//   done        one-cycle pulse; result is valid from this cycle on
//   result      saturated signed Q16.16 output; holds until the next result
//   sat         result was clamped by saturation; updates with result
// -----------------------------------------------------------------------------
module neuron_mac_seq #(
    parameter int N_IN   = 10,
    parameter int DATA_W = 32,
    parameter int FRAC   = 16,
    parameter int ACC_W  = 56
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     relu_en,
    input  logic [N_IN*DATA_W-1:0]   data_vec,
    input  logic [N_IN*DATA_W-1:0]   weight_vec,
    input  logic [DATA_W-1:0]        bias,
    output logic                     busy,
    output logic                     done,
    output logic [DATA_W-1:0]        result,
    output logic                     sat
);

    localparam int IDX_W = (N_IN > 1) ? $clog2(N_IN) : 1;
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(N_IN - 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_MAC  = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    // Saturation bounds, sign-extended to the accumulator width
    localparam logic signed [ACC_W-1:0] SAT_MAX =
        {{(ACC_W-DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SAT_MIN =
        {{(ACC_W-DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    // Returns {sat_flag, clamped_value} for a full-width accumulator value
    function automatic logic [DATA_W:0] sat_clamp(input logic signed [ACC_W-1:0] v);
        logic [DATA_W:0] r;
        if (v > SAT_MAX) begin
            r = {1'b1, SAT_MAX[DATA_W-1:0]};
        end else if (v < SAT_MIN) begin
            r = {1'b1, SAT_MIN[DATA_W-1:0]};
        end else begin
            r = {1'b0, v[DATA_W-1:0]};
        end
        return r;
    endfunction

    logic [1:0]                state_q,  state_d;
    logic [IDX_W-1:0]          idx_q,    idx_d;
    logic signed [ACC_W-1:0]   acc_q,    acc_d;
    logic [N_IN*DATA_W-1:0]    data_q,   data_d;
    logic [N_IN*DATA_W-1:0]    weight_q, weight_d;
    logic                      relu_q,   relu_d;
    logic                      busy_q,   busy_d;
    logic                      done_q,   done_d;
    logic [DATA_W-1:0]         result_q, result_d;
    logic                      sat_q,    sat_d;

    logic signed [DATA_W-1:0]   d_sel_s;
    logic signed [DATA_W-1:0]   w_sel_s;
    logic signed [2*DATA_W-1:0] prod_s;
    logic signed [ACC_W-1:0]    term_s;
    logic signed [ACC_W-1:0]    relu_v_s;
    logic [DATA_W:0]            clamp_s;
    logic                       accept_s;

    // Current product term: arithmetic shift truncates toward -inf
    always_comb begin
        d_sel_s  = data_q[int'(idx_q)*DATA_W +: DATA_W];
        w_sel_s  = weight_q[int'(idx_q)*DATA_W +: DATA_W];
        prod_s   = (2*DATA_W)'(d_sel_s) * (2*DATA_W)'(w_sel_s);
        term_s   = ACC_W'(prod_s >>> FRAC);
        // ReLU is applied before saturation, so a zeroed value never flags sat
        relu_v_s = (relu_q && acc_q[ACC_W-1]) ? {ACC_W{1'b0}} : acc_q;
        clamp_s  = sat_clamp(relu_v_s);
        // The DONE cycle also accepts, giving N_IN+1 cycle back-to-back throughput
        accept_s = start && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    end

    // Next-state logic for the sequencer, accumulator and output registers
    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        acc_d    = acc_q;
        data_d   = data_q;
        weight_d = weight_q;
        relu_d   = relu_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        result_d = result_q;
        sat_d    = sat_q;

        case (state_q)
            ST_IDLE: begin
                busy_d = 1'b0;
            end
            ST_MAC: begin
                acc_d = acc_q + term_s;
                idx_d = idx_q + IDX_W'(1'b1);
                if (idx_q == IDX_LAST) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_MAC;
                end
            end
            ST_DONE: begin
                result_d = clamp_s[DATA_W-1:0];
                sat_d    = clamp_s[DATA_W];
                done_d   = 1'b1;
                busy_d   = 1'b0;
                state_d  = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
            end
        endcase

        // A new run overrides the return to IDLE; the result above still lands
        if (accept_s) begin
            data_d   = data_vec;
            weight_d = weight_vec;
            relu_d   = relu_en;
            acc_d    = {{(ACC_W-DATA_W){bias[DATA_W-1]}}, bias};
            idx_d    = {IDX_W{1'b0}};
            busy_d   = 1'b1;
            state_d  = ST_MAC;
        end else begin
            state_d  = state_d;
        end
    end

    // State registers with synchronous reset
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            idx_q    <= {IDX_W{1'b0}};
            acc_q    <= {ACC_W{1'b0}};
            data_q   <= {(N_IN*DATA_W){1'b0}};
            weight_q <= {(N_IN*DATA_W){1'b0}};
            relu_q   <= 1'b0;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            result_q <= {DATA_W{1'b0}};
            sat_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            acc_q    <= acc_d;
            data_q   <= data_d;
            weight_q <= weight_d;
            relu_q   <= relu_d;
            busy_q   <= busy_d;
            done_q   <= done_d;
            result_q <= result_d;
            sat_q    <= sat_d;
        end
    end

    assign busy   = busy_q;
    assign done   = done_q;
    assign result = result_q;
    assign sat    = sat_q;

endmodule

// File: tb/tb_neuron_mac_seq.sv
module tb_neuron_mac_seq;

    localparam int N  = 10;
    localparam int W  = 32;
    localparam int VW = N * W;

    logic          clk = 1'b0;
    logic          reset;
    logic          start;
    logic          relu_en;
    logic [VW-1:0] data_vec;
    logic [VW-1:0] weight_vec;
    logic [W-1:0]  bias;
    logic          busy;
    logic          done;
    logic [W-1:0]  result;
    logic          sat;

    int checks = 0;
    int errors = 0;

    neuron_mac_seq dut (
        .clk        (clk),
        .reset      (reset),
        .start      (start),
        .relu_en    (relu_en),
        .data_vec   (data_vec),
        .weight_vec (weight_vec),
        .bias       (bias),
        .busy       (busy),
        .done       (done),
        .result     (result),
        .sat        (sat)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [VW-1:0] dv;
        logic [VW-1:0] wv;
        logic [W-1:0]  b;
        logic          relu;
        logic [W-1:0]  exp_res;
        logic          exp_sat;
    } vec_t;

    vec_t vecs[$];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp_v);
        end
    endtask

    function automatic logic [VW-1:0] fill(input logic [W-1:0] x);
        logic [VW-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = x;
        return v;
    endfunction

    // Reference: real-number style Q16.16 dot product with floor-truncated terms
    function automatic logic [W:0] model(input logic [VW-1:0] dv, input logic [VW-1:0] wv,
                                        input logic [W-1:0] b, input logic relu);
        longint acc;
        longint p;
        longint hi;
        longint lo;
        hi  = 64'sd2147483647;
        lo  = -64'sd2147483648;
        acc = longint'(signed'(b));
        for (int i = 0; i < N; i++) begin
            p   = longint'(signed'(dv[i*W +: W])) * longint'(signed'(wv[i*W +: W]));
            acc = acc + (p >>> 16);
        end
        if (relu && acc < 0) acc = 0;
        if (acc > hi) return {1'b1, 32'h7FFFFFFF};
        if (acc < lo) return {1'b1, 32'h80000000};
        return {1'b0, acc[31:0]};
    endfunction

    // One full run with latency, busy and single-pulse checks
    task automatic run_op(input logic [VW-1:0] dv, input logic [VW-1:0] wv, input logic [W-1:0] b,
                          input logic r, output logic [W-1:0] res, output logic s);
        int   cnt;
        logic busy_ok;
        logic seen;
        data_vec = dv; weight_vec = wv; bias = b; relu_en = r; start = 1'b1;
        tick();
        start   = 1'b0;
        busy_ok = busy;
        cnt     = 0;
        seen    = 1'b0;
        while (!seen && cnt < 20) begin
            tick();
            cnt++;
            if (done) seen = 1'b1;
            else if (!busy) busy_ok = 1'b0;
        end
        chk("done_latency", cnt, 11);
        chk("busy_during_run", busy_ok, 1'b1);
        chk("busy_at_done", busy, 1'b0);
        res = result;
        s   = sat;
        tick();
        chk("done_single_pulse", done, 1'b0);
    endtask

    initial begin
        logic [W-1:0] res;
        logic         s;
        logic [W:0]   m;
        logic [VW-1:0] dv;
        logic [VW-1:0] wv;
        logic [VW-1:0] t2d;
        logic [VW-1:0] t2w;
        int pulses;
        int first_at;
        int last_at;
        logic res_ok;
        logic busy_all;

        reset = 1'b1; start = 1'b0; relu_en = 1'b0;
        data_vec = '0; weight_vec = '0; bias = '0;
        repeat (3) tick();
        reset = 1'b0;
        chk("reset_busy", busy, 1'b0);
        chk("reset_done", done, 1'b0);
        chk("reset_result", result, 32'h0);
        chk("reset_sat", sat, 1'b0);

        // Directed table
        t2d = '0; t2d[31:0] = 32'hFFFE0000;
        t2w = '0; t2w[31:0] = 32'h00018000;
        vecs.push_back('{fill(32'h00010000), fill(32'h00010000), 32'h0, 1'b0, 32'h000A0000, 1'b0});
        vecs.push_back('{t2d, t2w, 32'h00008000, 1'b0, 32'hFFFD8000, 1'b0});
        vecs.push_back('{t2d, t2w, 32'h00008000, 1'b1, 32'h00000000, 1'b0});
        vecs.push_back('{fill(32'h7FFF0000), fill(32'h7FFF0000), 32'h0, 1'b0, 32'h7FFFFFFF, 1'b1});
        vecs.push_back('{fill(32'h7FFF0000), fill(32'h80010000), 32'h0, 1'b0, 32'h80000000, 1'b1});
        vecs.push_back('{fill(32'h7FFF0000), fill(32'h80010000), 32'h0, 1'b1, 32'h00000000, 1'b0});
        vecs.push_back('{fill(32'h0), fill(32'h0), 32'h7FFFFFFF, 1'b0, 32'h7FFFFFFF, 1'b0});
        vecs.push_back('{fill(32'h0), fill(32'h0), 32'h80000000, 1'b0, 32'h80000000, 1'b0});
        // -2^-16 * 2^-16 floors to -2^-16 per term: ten terms give -10 LSB
        vecs.push_back('{fill(32'hFFFFFFFF), fill(32'h00000001), 32'h0, 1'b0, 32'hFFFFFFF6, 1'b0});

        foreach (vecs[k]) begin
            run_op(vecs[k].dv, vecs[k].wv, vecs[k].b, vecs[k].relu, res, s);
            chk($sformatf("vec%0d_result", k), res, vecs[k].exp_res);
            chk($sformatf("vec%0d_sat", k), s, vecs[k].exp_sat);
        end

        // Randomized runs against the reference model
        for (int k = 0; k < 16; k++) begin
            for (int i = 0; i < N; i++) begin
                if (k % 2 == 0) begin
                    dv[i*W +: W] = $urandom_range(0, 32'h000FFFFF) - 32'h00080000;
                    wv[i*W +: W] = $urandom_range(0, 32'h000FFFFF) - 32'h00080000;
                end else begin
                    dv[i*W +: W] = $urandom;
                    wv[i*W +: W] = $urandom;
                end
            end
            bias    = $urandom;
            relu_en = 1'(($urandom_range(0, 1)));
            m = model(dv, wv, bias, relu_en);
            run_op(dv, wv, bias, relu_en, res, s);
            chk($sformatf("rand%0d_result", k), res, m[W-1:0]);
            chk($sformatf("rand%0d_sat", k), s, m[W]);
        end

        // Start while busy, with inputs changed after the accept edge
        data_vec = fill(32'h00010000); weight_vec = fill(32'h00010000); bias = '0; relu_en = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        pulses = 0; first_at = -1; res = '0;
        for (int c = 1; c <= 30; c++) begin
            if (c == 4) begin
                data_vec = '0;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            tick();
            if (done) begin
                pulses++;
                if (first_at < 0) begin first_at = c; res = result; end
            end
        end
        start = 1'b0;
        chk("ignore_start_pulses", pulses, 1);
        chk("ignore_start_latency", first_at, 11);
        chk("ignore_start_result", res, 32'h000A0000);

        // Reset in the middle of MAC aborts with no done
        data_vec = fill(32'h00010000);
        start = 1'b1; tick(); start = 1'b0;
        repeat (5) tick();
        reset = 1'b1; tick(); reset = 1'b0;
        chk("abort_busy", busy, 1'b0);
        chk("abort_result", result, 32'h0);
        chk("abort_sat", sat, 1'b0);
        pulses = 0;
        for (int c = 0; c < 15; c++) begin
            tick();
            if (done) pulses++;
        end
        chk("abort_no_done", pulses, 0);
        run_op(t2d, t2w, 32'h00008000, 1'b0, res, s);
        chk("after_abort_result", res, 32'hFFFD8000);

        // Continuous start: one result every 11 cycles
        data_vec = fill(32'h00010000); weight_vec = fill(32'h00010000); bias = '0; relu_en = 1'b0;
        start = 1'b1;
        pulses = 0; first_at = -1; last_at = -1; res_ok = 1'b1; busy_all = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            tick();
            if (!busy) busy_all = 1'b0;
            if (done) begin
                pulses++;
                if (result !== 32'h000A0000) res_ok = 1'b0;
                if (first_at < 0) first_at = c;
                else chk($sformatf("b2b_gap%0d", pulses), c - last_at, 11);
                last_at = c;
            end
        end
        start = 1'b0;
        chk("b2b_first", first_at, 12);
        chk("b2b_pulses", pulses, 5);
        chk("b2b_result", res_ok, 1'b1);
        chk("b2b_busy_held", busy_all, 1'b1);
        repeat (15) tick();
        chk("b2b_idle", busy, 1'b0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
